// File: rtl/map_pkg.sv
// map_pkg: shared widths, tile codes, requester and sequencer encodings for the map RAM arbiter
package map_pkg;
  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 4;
  localparam int MAP_TILES = 300;
  localparam int N_BLAST   = 10;
  localparam int IDX_W     = $clog2(N_BLAST);
  typedef enum logic [DATA_W-1:0] {
    TILE_EMPTY    = 4'h0,
    TILE_WALL     = 4'h1,
    TILE_BRICK    = 4'h2,
    TILE_SPEED_PU = 4'h3,
    TILE_LIVES_PU = 4'h4
  } tile_e;
  typedef enum logic [1:0] {REQ_P1, REQ_P2, REQ_BLAST} req_e;
  typedef enum logic [2:0] {B_IDLE, B_CHECK, B_RD, B_WAIT, B_WR, B_NEXT, B_DONE} blast_st_e;
  // Round-robin successor: P1 -> P2 -> BLAST -> P1
  function automatic req_e req_after(input req_e r);
    return r == REQ_P1 ? REQ_P2 : r == REQ_P2 ? REQ_BLAST : REQ_P1;
  endfunction
endpackage

// File: rtl/blast_clear_seq.sv
// blast_clear_seq: walks the latched blast list and overwrites BRICK tiles with EMPTY through the arbiter
module blast_clear_seq
  import map_pkg::*;
(
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           i_start,
  input  logic [N_BLAST-1:0][ADDR_W-1:0] i_list,
  input  logic                           i_gnt,
  input  logic                           i_rvalid,
  input  logic [DATA_W-1:0]              i_rdata,
  output logic                           o_req,
  output logic                           o_we,
  output logic [ADDR_W-1:0]              o_addr,
  output logic [DATA_W-1:0]              o_wdata,
  output logic                           o_busy,
  output logic                           o_done
);
  blast_st_e                     r_state, w_next;
  logic [N_BLAST-1:0][ADDR_W-1:0] r_list;
  logic [IDX_W-1:0]              r_idx;
  logic [ADDR_W-1:0]             w_cur;

  assign w_cur   = r_list[r_idx];
  assign o_req   = (r_state == B_RD) || (r_state == B_WR);
  assign o_we    = r_state == B_WR;
  assign o_addr  = w_cur;
  assign o_wdata = TILE_EMPTY;
  assign o_busy  = (r_state != B_IDLE) && (r_state != B_DONE);
  assign o_done  = r_state == B_DONE;

  // Next state: out-of-map entries are skipped, only a BRICK read leads to a write
  always_comb begin
    w_next = r_state;
    case (r_state)
      B_IDLE:  w_next = i_start ? B_CHECK : B_IDLE;
      B_CHECK: w_next = (w_cur >= ADDR_W'(MAP_TILES)) ? B_NEXT : B_RD;
      B_RD:    w_next = i_gnt ? B_WAIT : B_RD;
      B_WAIT:  w_next = !i_rvalid ? B_WAIT : (i_rdata == TILE_BRICK) ? B_WR : B_NEXT;
      B_WR:    w_next = i_gnt ? B_NEXT : B_WR;
      B_NEXT:  w_next = (r_idx == IDX_W'(N_BLAST-1)) ? B_DONE : B_CHECK;
      B_DONE:  w_next = B_IDLE;
      default: w_next = B_IDLE;
    endcase
  end

  // State, list latch (only from IDLE, so a start while busy is ignored) and index
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= B_IDLE;
      r_list  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == B_IDLE && i_start) begin
        r_list <= i_list;
        r_idx  <= '0;
      end
      if (r_state == B_NEXT && w_next == B_CHECK) r_idx <= r_idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/map_ram_arbiter.sv
// map_ram_arbiter: single-port tile-map RAM owner; video has priority, P1/P2/BLAST share the rest round-robin
module map_ram_arbiter
  import map_pkg::*;
(
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           vid_req,
  input  logic [ADDR_W-1:0]              vid_addr,
  output logic                           vid_rvalid,
  output logic [DATA_W-1:0]              vid_rdata,
  input  logic                           p1_req,
  input  logic [ADDR_W-1:0]              p1_addr,
  output logic                           p1_gnt,
  output logic                           p1_rvalid,
  output logic [DATA_W-1:0]              p1_rdata,
  input  logic                           p2_req,
  input  logic [ADDR_W-1:0]              p2_addr,
  output logic                           p2_gnt,
  output logic                           p2_rvalid,
  output logic [DATA_W-1:0]              p2_rdata,
  input  logic                           blast_start,
  input  logic [N_BLAST-1:0][ADDR_W-1:0] blast_addr,
  output logic                           blast_busy,
  output logic                           blast_done,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic                           ram_we,
  output logic [DATA_W-1:0]              ram_wdata,
  input  logic [DATA_W-1:0]              ram_rdata
);
  logic              w_bl_req, w_bl_we, w_bl_gnt, w_vid, w_any;
  logic [ADDR_W-1:0] w_bl_addr;
  logic [DATA_W-1:0] w_bl_wdata;
  logic [2:0]        w_req;
  req_e              w_c1, w_c2, w_win, r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_vid_rv, r_p1_rv, r_p2_rv, r_bl_rv;

  blast_clear_seq u_seq (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .i_start  (blast_start),
    .i_list   (blast_addr),
    .i_gnt    (w_bl_gnt),
    .i_rvalid (r_bl_rv),
    .i_rdata  (ram_rdata),
    .o_req    (w_bl_req),
    .o_we     (w_bl_we),
    .o_addr   (w_bl_addr),
    .o_wdata  (w_bl_wdata),
    .o_busy   (blast_busy),
    .o_done   (blast_done)
  );

  // Reset gates the combinational grant path so the port is quiet with no clock
  assign w_vid = Reset_n & vid_req;
  assign w_req = {w_bl_req, p2_req, p1_req} & {3{Reset_n & ~vid_req}};

  // First requester at or after the pointer wins
  always_comb begin
    w_c1  = req_after(r_ptr);
    w_c2  = req_after(w_c1);
    w_any = |w_req;
    w_win = w_req[r_ptr] ? r_ptr : w_req[w_c1] ? w_c1 : w_c2;
  end

  assign p1_gnt     = w_any && w_win == REQ_P1;
  assign p2_gnt     = w_any && w_win == REQ_P2;
  assign w_bl_gnt   = w_any && w_win == REQ_BLAST;
  assign ram_addr   = w_vid ? vid_addr : !w_any ? r_addr :
                      w_win == REQ_P1 ? p1_addr : w_win == REQ_P2 ? p2_addr : w_bl_addr;
  assign ram_we     = w_bl_gnt & w_bl_we;
  assign ram_wdata  = ram_we ? w_bl_wdata : '0;
  assign vid_rvalid = r_vid_rv;
  assign p1_rvalid  = r_p1_rv;
  assign p2_rvalid  = r_p2_rv;
  assign vid_rdata  = r_vid_rv ? ram_rdata : '0;
  assign p1_rdata   = r_p1_rv ? ram_rdata : '0;
  assign p2_rdata   = r_p2_rv ? ram_rdata : '0;

  // Pointer advance past the winner, held address, and one-cycle-late read valids
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr    <= REQ_P1;
      r_addr   <= '0;
      r_vid_rv <= 1'b0;
      r_p1_rv  <= 1'b0;
      r_p2_rv  <= 1'b0;
      r_bl_rv  <= 1'b0;
    end else begin
      r_addr   <= ram_addr;
      r_vid_rv <= w_vid;
      r_p1_rv  <= p1_gnt;
      r_p2_rv  <= p2_gnt;
      r_bl_rv  <= w_bl_gnt & ~w_bl_we;
      if (w_any) r_ptr <= req_after(w_win);
    end
  end
endmodule

// File: tb/tb_map_ram_arbiter.sv
// tb_map_ram_arbiter: vector table, hand corner sequences and randomized run against a rotating-priority model
module tb_map_ram_arbiter;
  import map_pkg::*;

  logic                           Clk = 1'b0, Reset_n = 1'b0;
  logic                           vid_req = 1'b0, p1_req = 1'b0, p2_req = 1'b0, blast_start = 1'b0;
  logic [ADDR_W-1:0]              vid_addr = '0, p1_addr = '0, p2_addr = '0;
  logic [N_BLAST-1:0][ADDR_W-1:0] blast_addr = '1;
  logic                           vid_rvalid, p1_gnt, p1_rvalid, p2_gnt, p2_rvalid;
  logic                           blast_busy, blast_done, ram_we;
  logic [DATA_W-1:0]              vid_rdata, p1_rdata, p2_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0]              ram_addr;

  always #5 Clk = ~Clk;

  map_ram_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p2_req(p2_req), .p2_addr(p2_addr), .p2_gnt(p2_gnt), .p2_rvalid(p2_rvalid), .p2_rdata(p2_rdata),
    .blast_start(blast_start), .blast_addr(blast_addr), .blast_busy(blast_busy), .blast_done(blast_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Registered single-port RAM with a bench backdoor for preloading
  logic [3:0] mem [1024];
  logic       fill = 1'b0, bd_we = 1'b0;
  logic [9:0] bd_addr = '0;
  logic [3:0] bd_data = '0;
  always @(posedge Clk) begin
    if (fill) for (int k = 0; k < 1024; k++) mem[k] <= 4'($urandom_range(0, 4));
    else if (bd_we) mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [3:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic set_list(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
    for (int i = 0; i < N_BLAST; i++) blast_addr[i] = 10'h3FF;
    blast_addr[0] = a0; blast_addr[1] = a1; blast_addr[2] = a2;
  endtask

  task automatic pulse_start();
    blast_start = 1'b1;
    tick();
    blast_start = 1'b0;
  endtask

  int wr_cnt = 0, done_cnt = 0, p2_blast = 0;
  logic busy_seen = 1'b0;
  logic [9:0] wa = '0;
  logic [3:0] wd = '0;

  task automatic wait_done(input int d0);
    for (int n = 0; n < 400 && done_cnt == d0; n++) tick();
  endtask

  // Reference model: a rotating priority list; the winner moves to the back
  bit         mon_en = 1'b0;
  int         ord[$] = '{0, 1, 2};
  logic       pv1 = 0, pv2 = 0, pvv = 0, g1 = 0, g2 = 0;
  logic [3:0] pd1 = 0, pd2 = 0, pdv = 0;
  always @(negedge Clk) begin
    if (ram_we) begin wr_cnt++; wa = ram_addr; wd = ram_wdata; end
    if (blast_done) done_cnt++;
    if (blast_busy) busy_seen = 1'b1;
    if (p2_gnt && blast_busy) p2_blast++;
    g1 = p1_gnt;
    g2 = p2_gnt;
    if (!Reset_n) begin
      ord = '{0, 1, 2};
      pv1 = 0; pv2 = 0; pvv = 0;
    end else begin
      int   win;
      logic r [3];
      win = -1;
      r[0] = p1_req; r[1] = p2_req; r[2] = 1'b0;
      if (!vid_req) foreach (ord[j]) if (win < 0 && r[ord[j]]) win = ord[j];
      if (mon_en) begin
        chk("m_p1_gnt", p1_gnt, win == 0);
        chk("m_p2_gnt", p2_gnt, win == 1);
        chk("m_vid_rvalid", vid_rvalid, pvv);
        chk("m_p1_rvalid", p1_rvalid, pv1);
        chk("m_p2_rvalid", p2_rvalid, pv2);
        if (pvv) chk("m_vid_rdata", vid_rdata, pdv);
        if (pv1) chk("m_p1_rdata", p1_rdata, pd1);
        if (pv2) chk("m_p2_rdata", p2_rdata, pd2);
        if (vid_req) chk("m_ram_addr_vid", ram_addr, vid_addr);
        chk("m_ram_we", ram_we, 0);
      end
      if (win >= 0) begin
        while (ord[0] != win) ord.push_back(ord.pop_front());
        ord.push_back(ord.pop_front());
      end
      pvv = vid_req; pdv = mem[vid_addr];
      pv1 = (win == 0); pd1 = mem[p1_addr];
      pv2 = (win == 1); pd2 = mem[p2_addr];
    end
  end

  typedef struct {
    logic       vid, p1, p2;
    logic [9:0] va, a1, a2;
    logic       g1, g2;
    logic [9:0] ea;
  } vec_t;
  vec_t tv [10];

  initial begin
    int w0, d0, pb0;
    bit found;
    tv[0] = '{1'b1, 1'b1, 1'b0, 10'd10,  10'd37, 10'd50, 1'b0, 1'b0, 10'd10};
    tv[1] = '{1'b0, 1'b1, 1'b1, 10'd10,  10'd37, 10'd50, 1'b1, 1'b0, 10'd37};
    tv[2] = '{1'b0, 1'b1, 1'b1, 10'd10,  10'd37, 10'd50, 1'b0, 1'b1, 10'd50};
    tv[3] = '{1'b0, 1'b1, 1'b1, 10'd10,  10'd37, 10'd50, 1'b1, 1'b0, 10'd37};
    tv[4] = '{1'b0, 1'b0, 1'b0, 10'd10,  10'd37, 10'd50, 1'b0, 1'b0, 10'd37};
    tv[5] = '{1'b0, 1'b0, 1'b1, 10'd10,  10'd37, 10'd51, 1'b0, 1'b1, 10'd51};
    tv[6] = '{1'b0, 1'b1, 1'b0, 10'd10,  10'd37, 10'd51, 1'b1, 1'b0, 10'd37};
    tv[7] = '{1'b1, 1'b1, 1'b1, 10'd299, 10'd37, 10'd51, 1'b0, 1'b0, 10'd299};
    tv[8] = '{1'b0, 1'b0, 1'b0, 10'd299, 10'd37, 10'd51, 1'b0, 1'b0, 10'd299};
    tv[9] = '{1'b0, 1'b1, 1'b1, 10'd299, 10'd37, 10'd50, 1'b0, 1'b1, 10'd50};

    fill = 1'b1;
    tick();
    fill = 1'b0;
    chk("reset_state", {vid_rvalid, vid_rdata, p1_gnt, p2_gnt, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata,
                        blast_busy, blast_done, ram_addr, ram_we}, 0);
    Reset_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      vid_req = tv[i].vid; p1_req = tv[i].p1; p2_req = tv[i].p2;
      vid_addr = tv[i].va; p1_addr = tv[i].a1; p2_addr = tv[i].a2;
      @(negedge Clk);
      chk($sformatf("tv%0d_p1_gnt", i), p1_gnt, tv[i].g1);
      chk($sformatf("tv%0d_p2_gnt", i), p2_gnt, tv[i].g2);
      chk($sformatf("tv%0d_ram_addr", i), ram_addr, tv[i].ea);
      tick();
    end
    vid_req = 0; p1_req = 0; p2_req = 0;

    poke(10'd37, 4'h1);
    vid_req = 1; vid_addr = 10'd100; p1_req = 1; p1_addr = 10'd37;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("vp_p1_blocked", p1_gnt, 0);
      tick();
    end
    vid_req = 0;
    @(negedge Clk);
    chk("vp_p1_gnt", p1_gnt, 1);
    tick();
    p1_req = 0;
    @(negedge Clk);
    chk("vp_p1_rvalid", p1_rvalid, 1);
    chk("vp_p1_rdata", p1_rdata, 4'h1);
    tick();
    mon_en = 1'b0;

    poke(10'd5, TILE_BRICK);
    poke(10'd6, TILE_WALL);
    set_list(10'd5, 10'd6, 10'd5);
    w0 = wr_cnt; d0 = done_cnt; busy_seen = 1'b0;
    pulse_start();
    wait_done(d0);
    chk("bc_writes", wr_cnt - w0, 1);
    chk("bc_waddr", wa, 5);
    chk("bc_wdata", wd, 0);
    chk("bc_ram5", mem[5], TILE_EMPTY);
    chk("bc_ram6", mem[6], TILE_WALL);
    chk("bc_done", done_cnt - d0, 1);
    chk("bc_busy_seen", busy_seen, 1);
    @(negedge Clk);
    chk("bc_busy_end", blast_busy, 0);
    tick();

    poke(10'd5, TILE_BRICK);
    p2_req = 1; p2_addr = 10'd5;
    w0 = wr_cnt; d0 = done_cnt; pb0 = p2_blast;
    pulse_start();
    wait_done(d0);
    chk("cont_done", done_cnt - d0, 1);
    chk("cont_writes", wr_cnt - w0, 1);
    chk("cont_interleave", p2_blast > pb0, 1);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge Clk);
      if (p2_rvalid) found = 1;
      else tick();
    end
    chk("cont_p2_rvalid", found, 1);
    chk("cont_p2_rdata", p2_rdata, TILE_EMPTY);
    tick();
    p2_req = 0;
    tick();

    poke(10'd5, TILE_BRICK);
    poke(10'd6, TILE_BRICK);
    set_list(10'd5, 10'h3FF, 10'h3FF);
    d0 = done_cnt;
    pulse_start();
    tick();
    set_list(10'd6, 10'h3FF, 10'h3FF);
    pulse_start();
    wait_done(d0);
    chk("rs_ram5", mem[5], TILE_EMPTY);
    chk("rs_ram6", mem[6], TILE_BRICK);
    repeat (30) tick();
    chk("rs_done_once", done_cnt - d0, 1);
    @(negedge Clk);
    chk("rs_busy", blast_busy, 0);
    tick();

    poke(10'd5, TILE_BRICK);
    set_list(10'd5, 10'h3FF, 10'h3FF);
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    p1_req = 1; p1_addr = 10'd37;
    tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_outputs_zero", {vid_rvalid, vid_rdata, p1_gnt, p2_gnt, p1_rvalid, p2_rvalid, p1_rdata, p2_rdata,
                             blast_busy, blast_done, ram_addr, ram_we}, 0);
    p1_req = 0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    repeat (30) tick();
    @(negedge Clk);
    chk("rst_busy", blast_busy, 0);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_write", wr_cnt - w0, 0);
    chk("rst_ram5", mem[5], TILE_BRICK);
    tick();

    Reset_n = 1'b0;
    repeat (2) tick();
    Reset_n = 1'b1;
    mon_en = 1'b1;
    p1_req = 1; p1_addr = 10'd37; p2_req = 1; p2_addr = 10'd50;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk($sformatf("rr%0d_p1_gnt", i), p1_gnt, i % 2 == 0);
      chk($sformatf("rr%0d_p2_gnt", i), p2_gnt, i % 2 == 1);
      if (i > 0) chk($sformatf("rr%0d_rvalid", i), {p1_rvalid, p2_rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01);
      tick();
    end
    p1_req = 0; p2_req = 0;
    tick();

    for (int n = 0; n < 600; n++) begin
      vid_req = ($urandom_range(0, 3) == 0);
      vid_addr = 10'($urandom_range(0, 299));
      if (!p1_req || g1) begin p1_req = ($urandom_range(0, 2) != 0); p1_addr = 10'($urandom_range(0, 299)); end
      if (!p2_req || g2) begin p2_req = ($urandom_range(0, 2) != 0); p2_addr = 10'($urandom_range(0, 299)); end
      tick();
    end
    vid_req = 0; p1_req = 0; p2_req = 0;
    repeat (2) tick();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
